// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier, registered into EX/MEM.
// Optional signed-overflow trap on ADD/SUB when EX_OVF_TRAP_EN is defined (adds out_ovf).
module ex_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             In_valid,
    input  logic             In_WB,
    input  logic             In_M,
    input  logic             In_EX,
    input  logic             In_RegDst,
    input  logic [3:0]       In_ALUCtl,
    input  logic [WIDTH-1:0] In_address,
    input  logic [WIDTH-1:0] In_Readdata1,
    input  logic [WIDTH-1:0] In_Readdata2,
    input  logic [WIDTH-1:0] In_extended,
    input  logic [4:0]       In_Instruction20_16,
    input  logic [4:0]       In_Instruction15_11,
    output logic             stall,
    output logic             out_valid,
    output logic             out_WB,
    output logic             out_M,
    output logic [WIDTH-1:0] out_ALUresult,
    output logic [WIDTH-1:0] out_Readdata2,
    output logic [WIDTH-1:0] out_branch_target,
    output logic             out_zero,
    output logic [4:0]       out_WriteReg
`ifdef EX_OVF_TRAP_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int unsigned N    = WIDTH / MUL_STEP;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpNor = 4'b1100;
    localparam logic [3:0] OpMul = 4'b1000;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [WIDTH-1:0]  acc_q, acc_d;

    logic              valid_d, wb_d, m_d, zero_d, ovf_d;
    logic [WIDTH-1:0]  result_d, rd2_d, bt_d;
    logic [4:0]        wreg_d;

    logic [WIDTH-1:0]  op_b, sum, diff, alu_res, partial, acc_next, target;
    logic [4:0]        dest;
    logic              ovf, last;

    assign op_b   = In_EX ? In_extended : In_Readdata2;
    assign sum    = In_Readdata1 + op_b;
    assign diff   = In_Readdata1 - op_b;
    assign target = In_address + (In_extended << 2);
    assign dest   = In_RegDst ? In_Instruction15_11 : In_Instruction20_16;
    assign last   = (state_q == StBusy) && (count_q == CntW'(N - 1));

    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        unique case (In_ALUCtl)
            OpAnd: alu_res = In_Readdata1 & op_b;
            OpOr:  alu_res = In_Readdata1 | op_b;
            OpAdd: begin
                alu_res = sum;
                ovf = (In_Readdata1[WIDTH-1] == op_b[WIDTH-1]) &&
                      (sum[WIDTH-1] != In_Readdata1[WIDTH-1]);
            end
            OpSub: begin
                alu_res = diff;
                ovf = (In_Readdata1[WIDTH-1] != op_b[WIDTH-1]) &&
                      (diff[WIDTH-1] != In_Readdata1[WIDTH-1]);
            end
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, $signed(In_Readdata1) < $signed(op_b)};
            OpNor: alu_res = ~(In_Readdata1 | op_b);
            default: alu_res = '0;
        endcase
    end

    // One step's partial product: low MUL_STEP multiplier bits against the shifted multiplicand.
    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < MUL_STEP; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
    end

    assign acc_next = acc_q + partial;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        stall    = 1'b0;
        valid_d  = 1'b0;
        wb_d     = 1'b0;
        m_d      = 1'b0;
        ovf_d    = 1'b0;
        result_d = out_ALUresult;
        rd2_d    = out_Readdata2;
        bt_d     = out_branch_target;
        zero_d   = out_zero;
        wreg_d   = out_WriteReg;
        unique case (state_q)
            StIdle: begin
                if (In_valid && (In_ALUCtl == OpMul)) begin
                    stall    = 1'b1;
                    state_d  = StBusy;
                    count_d  = '0;
                    mcand_d  = In_Readdata1;
                    mplier_d = op_b;
                    acc_d    = '0;
                end else if (In_valid) begin
                    valid_d  = 1'b1;
                    wb_d     = In_WB;
                    m_d      = In_M;
                    result_d = alu_res;
                    rd2_d    = In_Readdata2;
                    bt_d     = target;
                    zero_d   = (alu_res == '0);
                    wreg_d   = dest;
`ifdef EX_OVF_TRAP_EN
                    ovf_d    = ovf;
                    if (ovf) wb_d = 1'b0;
`endif
                end
            end
            StBusy: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << MUL_STEP;
                mplier_d = mplier_q >> MUL_STEP;
                count_d  = count_q + 1'b1;
                if (last) begin
                    state_d  = StIdle;
                    valid_d  = 1'b1;
                    wb_d     = In_WB;
                    m_d      = In_M;
                    result_d = acc_next;
                    rd2_d    = In_Readdata2;
                    bt_d     = target;
                    zero_d   = (acc_next == '0);
                    wreg_d   = dest;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            count_q           <= '0;
            mcand_q           <= '0;
            mplier_q          <= '0;
            acc_q             <= '0;
            out_valid         <= 1'b0;
            out_WB            <= 1'b0;
            out_M             <= 1'b0;
            out_ALUresult     <= '0;
            out_Readdata2     <= '0;
            out_branch_target <= '0;
            out_zero          <= 1'b0;
            out_WriteReg      <= '0;
        end else begin
            state_q           <= state_d;
            count_q           <= count_d;
            mcand_q           <= mcand_d;
            mplier_q          <= mplier_d;
            acc_q             <= acc_d;
            out_valid         <= valid_d;
            out_WB            <= wb_d;
            out_M             <= m_d;
            out_ALUresult     <= result_d;
            out_Readdata2     <= rd2_d;
            out_branch_target <= bt_d;
            out_zero          <= zero_d;
            out_WriteReg      <= wreg_d;
        end
    end

`ifdef EX_OVF_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) out_ovf <= 1'b0;
        else     out_ovf <= ovf_d;
    end
`else
    logic unused_ovf;
    assign unused_ovf = ^{ovf, ovf_d};
`endif

endmodule
